// File: rtl/adc_spi_rx_pkg.sv
// adc_spi_rx_pkg: shared state encoding, output width and midscale offset for adc_spi_rx
package adc_spi_rx_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int OUT_W = 16;

    function automatic logic [OUT_W-1:0] midscale(input int bits);
        return OUT_W'(1) << (bits - 1);
    endfunction

    localparam logic [OUT_W-1:0] MIDSCALE = midscale(12);
endpackage

// File: rtl/adc_spi_rx_sclk_divider.sv
// sclk_divider: ticks once every HALF_DIV clk cycles, held at zero while clr is high
module sclk_divider #(
    parameter int HALF_DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt;

    assign tick = !clr && cnt == 8'(HALF_DIV - 1);

    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) cnt <= '0;
        else      cnt <= (clr || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: free-running SPI ADC frame receiver with offset-binary to two's complement conversion
module adc_spi_rx
    import adc_spi_rx_pkg::*;
#(
    parameter int HALF_DIV   = 4,
    parameter int QUIET_CYC  = 8,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    sdata,
    output logic                    cs,
    output logic                    sclk,
    output logic signed [OUT_W-1:0] dato_final,
    output logic                    dato_valid
);
    localparam int BW = $clog2(FRAME_BITS + 1);

    logic [1:0]            state;
    logic [7:0]            quiet;
    logic [BW-1:0]         bits;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nxt;
    logic [OUT_W-1:0]      conv;
    logic                  tick;
    logic                  last;

    sclk_divider #(.HALF_DIV(HALF_DIV)) u_div (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (state != SHIFT),
        .tick (tick)
    );

    assign shreg_nxt = FRAME_BITS'({shreg, sdata});
    assign conv      = OUT_W'(shreg_nxt[DATA_BITS-1:0]) - midscale(DATA_BITS);
    // the final rising sclk edge and the move to DONE share one clk edge
    assign last      = tick && !sclk && bits == BW'(FRAME_BITS - 1);

    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            state      <= IDLE;
            quiet      <= '0;
            bits       <= '0;
            shreg      <= '0;
            cs         <= 1'b1;
            sclk       <= 1'b1;
            dato_final <= '0;
            dato_valid <= 1'b0;
        end else begin
            dato_valid <= 1'b0;
            case (state)
                IDLE: begin
                    quiet <= quiet + 8'd1;
                    if (quiet == 8'(QUIET_CYC - 1)) begin
                        quiet <= '0;
                        state <= SHIFT;
                        cs    <= 1'b0;
                    end
                end
                SHIFT: if (tick) begin
                    sclk <= ~sclk;
                    if (!sclk) begin
                        shreg <= shreg_nxt;
                        bits  <= bits + BW'(1);
                    end
                    if (last) begin
                        bits       <= '0;
                        state      <= DONE;
                        cs         <= 1'b1;
                        dato_valid <= 1'b1;
                        dato_final <= conv;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_adc_spi_rx.sv
// tb_adc_spi_rx: scoreboard bench with an MSB-first ADC model driving sdata on sclk falling edges
module tb_adc_spi_rx;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic sdata = 1'b0;
    logic cs, sclk, dato_valid;
    logic signed [15:0] dato_final;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] frames[$];
    int exp_q[$];

    always #5 Clk = ~Clk;

    adc_spi_rx #(.HALF_DIV(2), .QUIET_CYC(4), .FRAME_BITS(16), .DATA_BITS(12)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .sdata      (sdata),
        .cs         (cs),
        .sclk       (sclk),
        .dato_final (dato_final),
        .dato_valid (dato_valid)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ADC model: latch a frame when cs falls, present the next bit on each sclk fall
    logic [15:0] cur = '0;
    int idx = -1;
    always @(negedge cs) begin
        cur = frames.size() != 0 ? frames.pop_front() : 16'h0000;
        idx = 15;
    end
    always @(negedge sclk)
        if (!cs && idx >= 0) begin
            sdata = cur[idx];
            idx--;
        end

    // monitor: protocol timing plus scoreboard pops on every dato_valid
    logic pcs = 1'b1, psclk = 1'b1, pvalid = 1'b0, prst = 1'b0;
    logic signed [15:0] pdato = '0;
    int rises = 0, low_w = 0, since = 0;
    bit have_valid = 0, aborted = 1;
    always @(negedge Clk) begin
        if (!Rst) begin
            aborted = 1;
            have_valid = 0;
        end
        if (pcs && !cs) begin
            check("cs_fall_sclk_high", sclk, 1);
            aborted = 0;
            rises = 0;
        end
        if (pcs && cs) check("sclk_still_while_cs_high", sclk, psclk);
        if (!pcs && sclk && !psclk) rises++;
        if (!cs) low_w = pcs ? 1 : low_w + 1;
        if (!pcs && cs && !aborted) begin
            check("cs_low_width", low_w, 64);
            check("sclk_rises", rises, 16);
        end
        since++;
        if (dato_valid) begin
            if (exp_q.size() == 0) fail_now($sformatf("unexpected_valid dato_final=%0d", dato_final));
            else check("dato_final", int'(dato_final), exp_q.pop_front());
            if (have_valid) check("valid_spacing", since, 69);
            have_valid = 1;
            since = 0;
        end
        if (pvalid) check("valid_width", dato_valid, 0);
        if (Rst && prst && !dato_valid) check("dato_hold", int'(dato_final), int'(pdato));
        pcs = cs;
        psclk = sclk;
        pvalid = dato_valid;
        prst = Rst;
        pdato = dato_final;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, cs, 1);
        check({tag, "_sclk"}, sclk, 1);
        check({tag, "_dato_final"}, int'(dato_final), 0);
        check({tag, "_dato_valid"}, dato_valid, 0);
    endtask

    task automatic release_and_time_quiet(input string tag);
        int n;
        @(negedge Clk);
        Rst = 1'b1;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (cs && n < 50);
        check(tag, n, 4);
    endtask

    task automatic wait_exp(input int left, input string tag);
        int n;
        n = 0;
        while (exp_q.size() > left && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() > left) fail_now(tag);
    endtask

    localparam logic [15:0] FRAME_TAB[6] = '{16'h0FFF, 16'h0800, 16'h0000, 16'hF123, 16'h0ABC, 16'h0ABC};
    localparam int EXP_TAB[5] = '{2047, 0, -2048, -1757, 700};

    initial begin
        int n;
        #3 Rst = 1'b0;
        #1 check_reset_outputs("reset");
        foreach (FRAME_TAB[i]) frames.push_back(FRAME_TAB[i]);
        foreach (EXP_TAB[i]) exp_q.push_back(EXP_TAB[i]);
        release_and_time_quiet("quiet_after_power_reset");
        wait_exp(1, "timeout_first_four_frames");
        n = 0;
        do begin
            @(posedge Clk);
            n++;
        end while (!(!cs && rises == 7) && n < 200);
        if (!(!cs && rises == 7)) fail_now("timeout_seventh_rise");
        #2 Rst = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) @(negedge Clk);
        check("abort_dato_hold", int'(dato_final), 0);
        release_and_time_quiet("quiet_after_abort");
        wait_exp(0, "timeout_frame_after_abort");
        repeat (10) @(negedge Clk);
        check("final_hold", int'(dato_final), 700);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
